jtag_halt_ctrl: RTL

Debug halt sequencer for the core. It converts halt, resume and optional single-step requests from the JTAG debug module into the level halt request consumed by the pipeline control block. It watches the resulting pipeline hold flag and reports `halted_o` only once the pipeline has actually drained. It sits between the JTAG debug module and the control block, on the core side of the JTAG clock-domain crossing.

---
 rtl/jtag_halt_ctrl_pkg.sv | 26 ++
 rtl/jtag_halt_ctrl.sv | 112 +++++++++++
 2 files changed

// File: rtl/jtag_halt_ctrl_pkg.sv
// Shared core defines: pipeline hold-flag encodings plus the debug halt sequencer
// state encodings and drain-counter width used by jtag_halt_ctrl.
package jtag_halt_ctrl_pkg;

  localparam int HoldFlagBusW = 3;
  typedef logic [HoldFlagBusW-1:0] Hold_Flag_Bus;

  localparam Hold_Flag_Bus Hold_None = 3'b000;
  localparam Hold_Flag_Bus Hold_Pc   = 3'b001;
  localparam Hold_Flag_Bus Hold_If   = 3'b010;
  localparam Hold_Flag_Bus Hold_Id   = 3'b011;

  localparam logic HoldEnable  = 1'b1;
  localparam logic HoldDisable = 1'b0;

  localparam int JHaltStateBus = 2;
  typedef enum logic [JHaltStateBus-1:0] {
    JHaltRun    = 2'd0,
    JHaltDrain  = 2'd1,
    JHaltHalted = 2'd2,
    JHaltStep   = 2'd3
  } jhalt_state_t;

  localparam int JHaltCntW = 4;

endpackage

// File: rtl/jtag_halt_ctrl.sv
// Debug halt sequencer: turns JTAG halt/resume/step requests into the pipeline
// halt request and reports halted once the pipeline has drained.
// Optional single-step support is built when JTAG_SINGLE_STEP_EN is defined.
module jtag_halt_ctrl
  import jtag_halt_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         halt_req_i,
  input  logic         resume_req_i,
  input  logic         step_req_i,
  input  logic         retire_i,
  input  logic         jump_flag_i,
  input  Hold_Flag_Bus hold_flag_i,
  output logic         jtag_halt_flag_o,
  output logic         halted_o,
  output logic         resume_ack_o
);

  localparam logic [JHaltCntW-1:0] DrainTarget = JHaltCntW'(DRAIN_CYCLES);
  localparam logic [JHaltCntW-1:0] CntMax      = '1;

  jhalt_state_t          state_q, state_d;
  logic [JHaltCntW-1:0]  cnt_q, cnt_d;
  logic                  ack_d;
  logic                  flag_d;
  logic                  halted_d;

`ifndef JTAG_SINGLE_STEP_EN
  logic unused_step_inputs;
  assign unused_step_inputs = step_req_i ^ retire_i;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    case (state_q)
      JHaltRun: begin
        if (halt_req_i) begin
          state_d = JHaltDrain;
          cnt_d   = '0;
        end
      end
      JHaltDrain: begin
        // A foreign hold (e.g. a bus stall on Hold_Pc) means the ID hold is not
        // really in force, so the drain window restarts from zero.
        if (resume_req_i) begin
          state_d = JHaltRun;
          cnt_d   = '0;
          ack_d   = 1'b1;
        end else if (hold_flag_i != Hold_Id) begin
          cnt_d = '0;
        end else if (cnt_q == DrainTarget) begin
          state_d = JHaltHalted;
          cnt_d   = '0;
        end else if (!jump_flag_i && cnt_q != CntMax) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      JHaltHalted: begin
        if (resume_req_i) begin
          state_d = JHaltRun;
          ack_d   = 1'b1;
        end
`ifdef JTAG_SINGLE_STEP_EN
        else if (step_req_i) begin
          state_d = JHaltStep;
        end
`endif
      end
`ifdef JTAG_SINGLE_STEP_EN
      JHaltStep: begin
        if (resume_req_i) begin
          state_d = JHaltRun;
          ack_d   = 1'b1;
        end else if (retire_i) begin
          state_d = JHaltDrain;
          cnt_d   = '0;
        end
      end
`endif
      default: begin
        state_d = JHaltRun;
        cnt_d   = '0;
      end
    endcase

    flag_d   = (state_d == JHaltDrain) || (state_d == JHaltHalted);
    halted_d = (state_d == JHaltHalted);
  end

  // Outputs are registered from the next state so they change on the same edge as the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= JHaltRun;
      cnt_q            <= '0;
      jtag_halt_flag_o <= HoldDisable;
      halted_o         <= 1'b0;
      resume_ack_o     <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      jtag_halt_flag_o <= flag_d ? HoldEnable : HoldDisable;
      halted_o         <= halted_d;
      resume_ack_o     <= ack_d;
    end
  end

endmodule
